// File: rtl/floating_32bit_alu_arb.sv
// floating_32bit_alu_arb
//   Round-robin arbiter that time-shares one float add/sub unit, one float
//   multiplier and (optionally) one float divider among NREQ requesters.
//   Each operation takes two cycles: grant/latch, then register the result.
//   The result is held until the consumer accepts it.
//
// Ports
//   CLK      : clock, all state updates on the rising edge
//   RST      : synchronous active-high reset
//   REQ_VLD  : per-requester request strobe            [NREQ]
//   REQ_OP   : per-requester opcode 00 add 01 sub 10 mul 11 div [2*NREQ]
//   REQ_INA  : per-requester operand A, IEEE-754 single [32*NREQ]
//   REQ_INB  : per-requester operand B, IEEE-754 single [32*NREQ]
//   REQ_RDY  : one-hot grant strobe (or zero)          [NREQ]
//   RES_VLD  : result valid
//   RES_ID   : requester that owns RES_OUT             [IDW]
//   RES_OUT  : result word                             [32]
//   RES_RDY  : result consumer ready
//   OPS_CNT  : count of accepted results, wraps        [16]
//
// Configuration
//   FLOATING_ARB_DIV_EN : when defined, a divider is built and opcode 11
//   returns INA/INB; otherwise opcode 11 returns the quiet NaN 7FC00000
//   with identical timing.
//
// Arithmetic notes: round-to-nearest-even; subnormal inputs and results are
// flushed to signed zero; every NaN result is the canonical 7FC00000.

module floating_32bit_alu_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ_VLD,
  input  logic [2*NREQ-1:0]   REQ_OP,
  input  logic [32*NREQ-1:0]  REQ_INA,
  input  logic [32*NREQ-1:0]  REQ_INB,
  output logic [NREQ-1:0]     REQ_RDY,
  output logic                RES_VLD,
  output logic [IDW-1:0]      RES_ID,
  output logic [31:0]         RES_OUT,
  input  logic                RES_RDY,
  output logic [15:0]         OPS_CNT
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, grant_idx, cand;
  logic           grant_en;
  logic [1:0]     sel_op, op_q;
  logic [31:0]    sel_ina, sel_inb, ina_q, inb_q;
  logic [31:0]    add_res, mul_res, div_res, unit_res;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

  // m carries the hidden bit at [26] and guard/round/sticky at [2:0].
  function automatic logic [31:0] round_pack(input logic s, input int e, input logic [26:0] m);
    logic [24:0] r;
    int          ee;
    logic        inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    r   = {1'b0, m[26:3]} + {24'd0, inc};
    ee  = e;
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 255) return {s, 8'hFF, 23'd0};
    if (ee <= 0)   return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  // Subtraction reaches this function with B's sign already flipped.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_hi, mag_lo;
    logic [26:0] mx, my, m;
    logic [27:0] sum;
    int          d, e;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31]))) return QNAN;
    if (is_inf(a)) return {a[31], 8'hFF, 23'd0};
    if (is_inf(b)) return {b[31], 8'hFF, 23'd0};
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    if (a[30:0] >= b[30:0]) begin
      mag_hi = a;
      mag_lo = b;
    end else begin
      mag_hi = b;
      mag_lo = a;
    end
    mx = {1'b1, mag_hi[22:0], 3'b000};
    my = {1'b1, mag_lo[22:0], 3'b000};
    d  = int'(mag_hi[30:23]) - int'(mag_lo[30:23]);
    e  = int'(mag_hi[30:23]);
    // Alignment shift folds every bit shifted out into the sticky bit.
    if (d > 26)
      my = 27'd1;
    else if (d > 0)
      my = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
    if (mag_hi[31] == mag_lo[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = e + 1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = mx - my;
      if (m == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 1;
        end
      end
    end
    return round_pack(mag_hi[31], e, m);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [26:0] m;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {p[47:22], |p[21:0]};
      e = e + 1;
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return round_pack(s, e, m);
  endfunction

`ifdef FLOATING_ARB_DIV_EN
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic [49:0] num, den, q, rem;
    logic [26:0] m;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b) || (is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_zero(b)) return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_inf(b)) return {s, 31'd0};
    num = {1'b1, a[22:0], 26'd0};
    den = {26'd0, 1'b1, b[22:0]};
    q   = num / den;
    rem = num % den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[26]) begin
      m = {q[26:1], q[0] | (rem != 50'd0)};
    end else begin
      m = {q[25:0], rem != 50'd0};
      e = e - 1;
    end
    return round_pack(s, e, m);
  endfunction
`endif

  // Round-robin search: scan offsets from largest to smallest so the last
  // hit, i.e. the nearest requester after last_grant, wins.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(last_grant) + off) % NREQ);
      if (REQ_VLD[cand]) grant_idx = cand;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op  = '0;
    sel_ina = '0;
    sel_inb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op  = REQ_OP[2*i +: 2];
        sel_ina = REQ_INA[32*i +: 32];
        sel_inb = REQ_INB[32*i +: 32];
      end
    end
  end

  // Next state and grant decision; a grant is possible from IDLE or when a
  // held result is being accepted, never while RST is high.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|REQ_VLD) begin
          grant_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = HOLD;
      HOLD: begin
        if (RES_RDY) begin
          if (|REQ_VLD) begin
            grant_en  = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RST) grant_en = 1'b0;
  end

  always_comb begin
    REQ_RDY = '0;
    if (grant_en) REQ_RDY[grant_idx] = 1'b1;
  end

  // Add and sub share one adder; opcode bit 0 flips B's sign.
  assign add_res = fp_add(ina_q, {inb_q[31] ^ op_q[0], inb_q[30:0]});
  assign mul_res = fp_mul(ina_q, inb_q);
`ifdef FLOATING_ARB_DIV_EN
  assign div_res = fp_div(ina_q, inb_q);
`else
  assign div_res = QNAN;
`endif

  always_comb begin
    unique case (op_q)
      2'b10:   unit_res = mul_res;
      2'b11:   unit_res = div_res;
      default: unit_res = add_res;
    endcase
  end

  // last_grant doubles as the latched owner ID of the in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      RES_VLD    <= 1'b0;
      RES_ID     <= '0;
      RES_OUT    <= '0;
      OPS_CNT    <= '0;
      last_grant <= IDW'(NREQ - 1);
      op_q       <= '0;
      ina_q      <= '0;
      inb_q      <= '0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        last_grant <= grant_idx;
        op_q       <= sel_op;
        ina_q      <= sel_ina;
        inb_q      <= sel_inb;
      end
      if (state == EXEC) begin
        RES_OUT <= unit_res;
        RES_ID  <= last_grant;
        RES_VLD <= 1'b1;
      end else if (state == HOLD && RES_RDY) begin
        RES_VLD <= 1'b0;
        OPS_CNT <= OPS_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_floating_32bit_alu_arb.sv
// tb_floating_32bit_alu_arb
//   Directed bench for floating_32bit_alu_arb (NREQ = 4). Expected results
//   are queued when a request is driven and popped when RES_VLD rises.

module tb_floating_32bit_alu_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

`ifdef FLOATING_ARB_DIV_EN
  localparam logic [31:0] DIV_EXP = 32'h4040_0000;
`else
  localparam logic [31:0] DIV_EXP = 32'h7FC0_0000;
`endif

  logic                CLK;
  logic                RST;
  logic [NREQ-1:0]     REQ_VLD;
  logic [2*NREQ-1:0]   REQ_OP;
  logic [32*NREQ-1:0]  REQ_INA;
  logic [32*NREQ-1:0]  REQ_INB;
  logic [NREQ-1:0]     REQ_RDY;
  logic                RES_VLD;
  logic [IDW-1:0]      RES_ID;
  logic [31:0]         RES_OUT;
  logic                RES_RDY;
  logic [15:0]         OPS_CNT;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  floating_32bit_alu_arb #(.NREQ(NREQ)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ_VLD (REQ_VLD),
    .REQ_OP  (REQ_OP),
    .REQ_INA (REQ_INA),
    .REQ_INB (REQ_INB),
    .REQ_RDY (REQ_RDY),
    .RES_VLD (RES_VLD),
    .RES_ID  (RES_ID),
    .RES_OUT (RES_OUT),
    .RES_RDY (RES_RDY),
    .OPS_CNT (OPS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one requester and queue the result it must eventually produce.
  task automatic applyStimulus(input int id, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expv);
    exp_t e;
    REQ_VLD[id]          = 1'b1;
    REQ_OP[2*id +: 2]    = op;
    REQ_INA[32*id +: 32] = a;
    REQ_INB[32*id +: 32] = b;
    e.id  = IDW'(id);
    e.res = expv;
    sb.push_back(e);
  endtask

  task automatic popAndCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_id"}, 32'(RES_ID), 32'(e.id));
      checkOutput({tag, "_out"}, RES_OUT, e.res);
    end
  endtask

  // Grant visible in the request cycle, EXEC next, result after the second edge.
  task automatic runSingle(input string tag, input int id, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    applyStimulus(id, op, a, b, expv);
    #1;
    checkOutput({tag, "_grant"}, 32'(REQ_RDY), 32'(1 << id));
    tick();
    REQ_VLD[id] = 1'b0;
    #1;
    checkOutput({tag, "_exec_vld"}, 32'(RES_VLD), 32'd0);
    checkOutput({tag, "_exec_rdy"}, 32'(REQ_RDY), 32'd0);
    tick();
    checkOutput({tag, "_vld"}, 32'(RES_VLD), 32'd1);
    popAndCheck(tag);
  endtask

  initial begin
    RST     = 1'b1;
    REQ_VLD = '0;
    REQ_OP  = '0;
    REQ_INA = '0;
    REQ_INB = '0;
    RES_RDY = 1'b0;

    // Reset state, and no grant while RST is high.
    tick();
    REQ_VLD = 4'hF;
    tick();
    checkOutput("rst_rdy", 32'(REQ_RDY), 32'd0);
    checkOutput("rst_vld", 32'(RES_VLD), 32'd0);
    checkOutput("rst_id", 32'(RES_ID), 32'd0);
    checkOutput("rst_out", RES_OUT, 32'd0);
    checkOutput("rst_cnt", 32'(OPS_CNT), 32'd0);
    REQ_VLD = '0;
    RST     = 1'b0;
    tick();

    // Req0 add 1.5 + 2.25 = 3.75.
    RES_RDY = 1'b1;
    runSingle("add0", 0, OP_ADD, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000);
    tick();
    checkOutput("add0_cnt", 32'(OPS_CNT), 32'd1);
    checkOutput("add0_clr", 32'(RES_VLD), 32'd0);

    // Req2 mul 1.5 * 2 = 3 held for five cycles while req3 waits.
    RES_RDY = 1'b0;
    runSingle("mul2", 2, OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    applyStimulus(3, OP_MUL, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("hold_vld", 32'(RES_VLD), 32'd1);
      checkOutput("hold_out", RES_OUT, 32'h4040_0000);
      checkOutput("hold_id", 32'(RES_ID), 32'd2);
      checkOutput("hold_rdy", 32'(REQ_RDY), 32'd0);
      tick();
    end
    RES_RDY = 1'b1;
    #1;
    checkOutput("hold_grant3", 32'(REQ_RDY), 32'b1000);
    tick();
    REQ_VLD = '0;
    checkOutput("hold_cnt", 32'(OPS_CNT), 32'd2);
    checkOutput("hold_clr", 32'(RES_VLD), 32'd0);
    tick();
    checkOutput("nan3_vld", 32'(RES_VLD), 32'd1);
    popAndCheck("nan3");
    tick();
    checkOutput("nan3_cnt", 32'(OPS_CNT), 32'd3);

    // Req3 sub 3 - 3 = +0.
    runSingle("sub3", 3, OP_SUB, 32'h4040_0000, 32'h4040_0000, 32'h0000_0000);
    tick();

    // Req1 div 6 / 2; NaN when the divider is not built, same timing.
    runSingle("div1", 1, OP_DIV, 32'h40C0_0000, 32'h4000_0000, DIV_EXP);
    tick();
    checkOutput("div1_cnt", 32'(OPS_CNT), 32'd5);

    // Reset in EXEC discards the operation and its count.
    applyStimulus(0, OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    tick();
    RST     = 1'b1;
    REQ_VLD = 4'hF;
    #1;
    checkOutput("rexec_rdy", 32'(REQ_RDY), 32'd0);
    tick();
    checkOutput("rexec_vld", 32'(RES_VLD), 32'd0);
    checkOutput("rexec_cnt", 32'(OPS_CNT), 32'd0);
    sb.delete();

    // All four requesting: grants 0,1,2,3,0,1, one result every two cycles.
    RST = 1'b0;
    REQ_OP  = {OP_ADD, OP_MUL, OP_SUB, OP_ADD};
    REQ_INA = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    REQ_INB = {4{32'h3F80_0000}};
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      #1;
      checkOutput("rr_grant", 32'(REQ_RDY), 32'(1 << (k % 4)));
      e.id = IDW'(k % 4);
      case (k % 4)
        0:       e.res = 32'h4000_0000;
        1:       e.res = 32'h3F80_0000;
        2:       e.res = 32'h4040_0000;
        default: e.res = 32'h40A0_0000;
      endcase
      sb.push_back(e);
      tick();
      checkOutput("rr_exec_vld", 32'(RES_VLD), 32'd0);
      tick();
      checkOutput("rr_vld", 32'(RES_VLD), 32'd1);
      popAndCheck("rr");
    end
    REQ_VLD = '0;
    tick();
    checkOutput("rr_cnt", 32'(OPS_CNT), 32'd6);
    checkOutput("rr_idle_vld", 32'(RES_VLD), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
